// File: rtl/bootld_pkg.sv
// Shared constants for the ITIM boot loader: state encoding, frame constants
// and the running-checksum helper.
package bootld_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_RUN  = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         CSUM_W        = 8;

    // Byte position inside a 32-bit word at which the word is complete.
    localparam logic [1:0] BYTE_POS_LAST = 2'd3;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                    input logic [7:0]        data);
        return acc + data;
    endfunction

    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == ST_LEN0) || (st == ST_LEN1) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/bootld_word_packer.sv
// Little-endian byte-to-word packer: four bytes shift in, first byte lands in
// [7:0]; word_valid pulses the cycle after the fourth byte.
module bootld_word_packer
    import bootld_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [1:0]  byte_cnt
);

    logic [31:0] shift_r;
    logic [1:0]  cnt_r;
    logic        word_valid_r;

    // Shift register, byte counter and word-complete strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r      <= 32'h0000_0000;
            cnt_r        <= 2'd0;
            word_valid_r <= 1'b0;
        end else if (clr) begin
            shift_r      <= 32'h0000_0000;
            cnt_r        <= 2'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= byte_valid && (cnt_r == BYTE_POS_LAST);
            if (byte_valid) begin
                shift_r <= {byte_data, shift_r[31:8]};
                cnt_r   <= cnt_r + 2'd1;
            end
        end
    end

    assign word_valid = word_valid_r;
    assign word_data  = shift_r;
    assign byte_cnt   = cnt_r;

endmodule

// File: rtl/itim_boot_loader.sv
// Boot sequencer: receives a framed image over UART, writes it into ITIM,
// verifies the checksum and releases the core. Optional echo: BOOTLD_ECHO_EN.
module itim_boot_loader
    import bootld_pkg::*;
#(
    parameter int         ADDR_W         = 12,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i_valid,
    input  logic [7:0]        rx_i_data,
    input  logic              boot_i_skip,
    output logic              itim_o_we,
    output logic [ADDR_W-1:0] itim_o_waddr,
    output logic [31:0]       itim_o_wdata,
    output logic              core_o_rst_n,
    output logic              boot_o_busy,
    output logic              boot_o_err,
    output logic              tx_o_valid,
    output logic [7:0]        tx_o_data,
    input  logic              tx_i_ready
);

    localparam int              TMO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [15:0]       len_r;
    logic [15:0]       len_full_s;
    logic [CSUM_W-1:0] csum_r;
    logic [ADDR_W-1:0] word_idx_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              err_r;
    logic              busy_r;
    logic              core_rst_n_r;
    logic              all_rcvd_r;

    logic              frame_start_s;
    logic              set_err_s;
    logic              busy_s;
    logic              tmo_hit_s;
    logic              csum_match_s;
    logic              pk_valid_s;
    logic              pk_word_valid_s;
    logic [31:0]       pk_word_s;
    logic [1:0]        pk_cnt_s;
    logic              last_word_s;

    assign busy_s       = is_busy_state(state_r);
    assign tmo_hit_s    = busy_s && !rx_i_valid && (tmo_cnt_r == TMO_LAST);
    assign csum_match_s = (rx_i_data == csum_r);
    assign len_full_s   = {rx_i_data, len_r[7:0]};
    // Once the last data byte is in, DATA lingers one cycle for the final write;
    // a byte arriving in that cycle is already the checksum.
    assign pk_valid_s   = (state_r == ST_DATA) && rx_i_valid && !all_rcvd_r;
    assign last_word_s  = (pk_cnt_s == BYTE_POS_LAST) &&
                          ({{(17-ADDR_W){1'b0}}, word_idx_r} == ({1'b0, len_r} - 17'd1));

    bootld_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (frame_start_s),
        .byte_valid (pk_valid_s),
        .byte_data  (rx_i_data),
        .word_valid (pk_word_valid_s),
        .word_data  (pk_word_s),
        .byte_cnt   (pk_cnt_s)
    );

    // Next-state decode for the frame parser.
    always_comb begin
        state_nxt_s   = state_r;
        frame_start_s = 1'b0;
        set_err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (boot_i_skip) begin
                    state_nxt_s = ST_RUN;
                end else if (rx_i_valid && (rx_i_data == MAGIC)) begin
                    state_nxt_s   = ST_LEN0;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEN0: begin
                if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    set_err_s   = 1'b1;
                end else if (rx_i_valid) begin
                    state_nxt_s = ST_LEN1;
                end else begin
                    state_nxt_s = ST_LEN0;
                end
            end
            ST_LEN1: begin
                if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    set_err_s   = 1'b1;
                end else if (!rx_i_valid) begin
                    state_nxt_s = ST_LEN1;
                end else if ({1'b0, len_full_s} > MAX_WORDS) begin
                    state_nxt_s = ST_ERR;
                    set_err_s   = 1'b1;
                end else if (len_full_s == 16'd0) begin
                    state_nxt_s = ST_CSUM;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DATA, ST_CSUM: begin
                if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    set_err_s   = 1'b1;
                end else if ((state_r == ST_CSUM) || all_rcvd_r) begin
                    if (!rx_i_valid) begin
                        state_nxt_s = ST_CSUM;
                    end else if (csum_match_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_ERR;
                        set_err_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            ST_ERR: begin
                if (rx_i_valid && (rx_i_data == MAGIC)) begin
                    state_nxt_s   = ST_LEN0;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame state, length, checksum, word index, timeout and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            len_r        <= 16'h0000;
            csum_r       <= {CSUM_W{1'b0}};
            word_idx_r   <= {ADDR_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            core_rst_n_r <= 1'b0;
            all_rcvd_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= is_busy_state(state_nxt_s);
            core_rst_n_r <= (state_nxt_s == ST_RUN);

            if (frame_start_s) begin
                err_r <= 1'b0;
            end else if (set_err_s) begin
                err_r <= 1'b1;
            end

            if ((state_r == ST_LEN0) && rx_i_valid) begin
                len_r[7:0] <= rx_i_data;
            end
            if ((state_r == ST_LEN1) && rx_i_valid) begin
                len_r[15:8] <= rx_i_data;
            end

            if (frame_start_s) begin
                csum_r <= {CSUM_W{1'b0}};
            end else if (pk_valid_s) begin
                csum_r <= csum_add(csum_r, rx_i_data);
            end

            if (frame_start_s) begin
                word_idx_r <= {ADDR_W{1'b0}};
            end else if (pk_word_valid_s) begin
                word_idx_r <= word_idx_r + ADDR_W'(1);
            end

            if (frame_start_s) begin
                all_rcvd_r <= 1'b0;
            end else if (pk_valid_s && last_word_s) begin
                all_rcvd_r <= 1'b1;
            end else if (state_nxt_s != ST_DATA) begin
                all_rcvd_r <= 1'b0;
            end

            if (busy_s && !rx_i_valid && !tmo_hit_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
        end
    end

    assign itim_o_we    = pk_word_valid_s;
    assign itim_o_waddr = word_idx_r;
    assign itim_o_wdata = pk_word_s;
    assign core_o_rst_n = core_rst_n_r;
    assign boot_o_busy  = busy_r;
    assign boot_o_err   = err_r;

`ifdef BOOTLD_ECHO_EN
    logic       tx_valid_r;
    logic [7:0] tx_data_r;
    logic       echo_accept_s;

    assign echo_accept_s = rx_i_valid && (state_r != ST_RUN);

    // One-entry echo buffer: a drain frees the slot for a same-cycle byte,
    // otherwise a byte arriving while full is not echoed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else if (tx_valid_r && tx_i_ready) begin
            tx_valid_r <= echo_accept_s;
            if (echo_accept_s) begin
                tx_data_r <= rx_i_data;
            end
        end else if (!tx_valid_r && echo_accept_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= rx_i_data;
        end
    end

    assign tx_o_valid = tx_valid_r;
    assign tx_o_data  = tx_data_r;
`else
    logic unused_tx_ready_s;

    assign unused_tx_ready_s = tx_i_ready;
    assign tx_o_valid        = 1'b0;
    assign tx_o_data         = 8'h00;
`endif

endmodule

// File: tb/tb_itim_boot_loader.sv
// Self-checking bench for itim_boot_loader: directed frames from the boot
// protocol plus randomized frames checked against an image-level model.
module tb_itim_boot_loader;

    localparam int ADDR_W = 12;
    localparam int TMO    = 100;

    logic              clk;
    logic              rst;
    logic              rx_i_valid;
    logic [7:0]        rx_i_data;
    logic              boot_i_skip;
    logic              itim_o_we;
    logic [ADDR_W-1:0] itim_o_waddr;
    logic [31:0]       itim_o_wdata;
    logic              core_o_rst_n;
    logic              boot_o_busy;
    logic              boot_o_err;
    logic              tx_o_valid;
    logic [7:0]        tx_o_data;
    logic              tx_i_ready;

    int checks = 0;
    int errors = 0;
    int bad_we = 0;

    logic [7:0]        frame_q[$];
    logic [31:0]       exp_q[$];
    logic [ADDR_W+31:0] wr_q[$];

    itim_boot_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO),
        .MAGIC          (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i_valid   (rx_i_valid),
        .rx_i_data    (rx_i_data),
        .boot_i_skip  (boot_i_skip),
        .itim_o_we    (itim_o_we),
        .itim_o_waddr (itim_o_waddr),
        .itim_o_wdata (itim_o_wdata),
        .core_o_rst_n (core_o_rst_n),
        .boot_o_busy  (boot_o_busy),
        .boot_o_err   (boot_o_err),
        .tx_o_valid   (tx_o_valid),
        .tx_o_data    (tx_o_data),
        .tx_i_ready   (tx_i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ITIM write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (itim_o_we) begin
            wr_q.push_back({itim_o_waddr, itim_o_wdata});
            if (!boot_o_busy) bad_we++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_q = {};
    endtask

    task automatic drive_frame(input int max_gap);
        foreach (frame_q[i]) begin
            rx_i_valid = 1'b1;
            rx_i_data  = frame_q[i];
            @(negedge clk);
            rx_i_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
    endtask

    // Image model: random words, sent as little-endian bytes after the header.
    task automatic build_frame(input int nwords, input bit bad_csum);
        int          sum;
        logic [31:0] w;
        logic [15:0] n;
        logic [7:0]  c;
        n = 16'(nwords);
        frame_q = {8'hA5, n[7:0], n[15:8]};
        exp_q   = {};
        sum     = 0;
        for (int k = 0; k < nwords; k++) begin
            w = $urandom;
            exp_q.push_back(w);
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(w[8*b +: 8]);
                sum += int'(w[8*b +: 8]);
            end
        end
        c = 8'(sum % 256);
        frame_q.push_back(bad_csum ? (c ^ 8'h01) : c);
    endtask

    task automatic check_result(input string tag, input bit exp_core, input bit exp_err);
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            chk({tag, "_waddr"}, 64'(wr_q[k][ADDR_W+31:32]), 64'(k));
            chk({tag, "_wdata"}, 64'(wr_q[k][31:0]), 64'(exp_q[k]));
        end
        chk({tag, "_core"}, 64'(core_o_rst_n), 64'(exp_core));
        chk({tag, "_err"}, 64'(boot_o_err), 64'(exp_err));
        chk({tag, "_busy"}, 64'(boot_o_busy), 64'd0);
        chk({tag, "_we_outside"}, 64'(bad_we), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        rx_i_valid  = 1'b0;
        rx_i_data   = 8'h00;
        boot_i_skip = 1'b0;
        tx_i_ready  = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_we",    64'(itim_o_we),    64'd0);
        chk("rst_waddr", 64'(itim_o_waddr), 64'd0);
        chk("rst_wdata", 64'(itim_o_wdata), 64'd0);
        chk("rst_core",  64'(core_o_rst_n), 64'd0);
        chk("rst_busy",  64'(boot_o_busy),  64'd0);
        chk("rst_err",   64'(boot_o_err),   64'd0);
        chk("rst_txv",   64'(tx_o_valid),   64'd0);
        chk("rst_txd",   64'(tx_o_data),    64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reference frame: two words, checksum 4A; core released right after.
        frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h37, 8'h00, 8'h00, 8'h00, 8'h4A};
        exp_q   = {32'h0000_0013, 32'h0000_0037};
        drive_frame(0);
        chk("a_core_next_cycle", 64'(core_o_rst_n), 64'd1);
        check_result("a", 1'b1, 1'b0);

        // Bad checksum, then resend with good checksum.
        do_reset();
        frame_q[11] = 8'h4B;
        drive_frame(2);
        check_result("bad", 1'b0, 1'b1);
        wr_q = {};
        frame_q[11] = 8'h4A;
        drive_frame(1);
        check_result("resend", 1'b1, 1'b0);

        // Inter-byte timeout mid-frame.
        do_reset();
        frame_q = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        exp_q   = {};
        drive_frame(0);
        repeat (TMO - 10) @(negedge clk);
        chk("tmo_still_busy", 64'(boot_o_busy), 64'd1);
        repeat (20) @(negedge clk);
        check_result("tmo", 1'b0, 1'b1);

        // Oversized length and zero length.
        do_reset();
        frame_q = {8'hA5, 8'h01, 8'h10};
        drive_frame(0);
        check_result("len_big", 1'b0, 1'b1);
        do_reset();
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        drive_frame(1);
        check_result("len_zero", 1'b1, 1'b0);

        // Skip loading, then bytes in RUN are ignored.
        boot_i_skip = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        chk("skip_core", 64'(core_o_rst_n), 64'd1);
        boot_i_skip = 1'b0;
        build_frame(2, 1'b0);
        exp_q = {};
        drive_frame(0);
        check_result("run_ignore", 1'b1, 1'b0);

        // Back-to-back frame interrupted by reset, then a clean reload.
        do_reset();
        build_frame(4, 1'b0);
        for (int k = 0; k < 9; k++) begin
            rx_i_valid = 1'b1;
            rx_i_data  = frame_q[k];
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we",    64'(itim_o_we),    64'd0);
        chk("mid_rst_waddr", 64'(itim_o_waddr), 64'd0);
        chk("mid_rst_wdata", 64'(itim_o_wdata), 64'd0);
        chk("mid_rst_busy",  64'(boot_o_busy),  64'd0);
        chk("mid_rst_core",  64'(core_o_rst_n), 64'd0);
        rx_i_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        wr_q = {};
        drive_frame(0);
        check_result("b2b", 1'b1, 1'b0);

`ifdef BOOTLD_ECHO_EN
        // Echo with TX stalled: only the first byte survives.
        do_reset();
        tx_i_ready = 1'b0;
        frame_q = {8'hA5, 8'h00, 8'h00};
        drive_frame(1);
        chk("echo_valid", 64'(tx_o_valid), 64'd1);
        chk("echo_data",  64'(tx_o_data),  64'hA5);
        tx_i_ready = 1'b1;
        @(negedge clk);
        chk("echo_drained", 64'(tx_o_valid), 64'd0);
        frame_q = {8'h00};
        exp_q   = {};
        drive_frame(0);
        check_result("echo_load", 1'b1, 1'b0);
        tx_i_ready = 1'b0;
`else
        chk("echo_off_valid", 64'(tx_o_valid), 64'd0);
        chk("echo_off_data",  64'(tx_o_data),  64'd0);
`endif

        // Randomized frames against the image model.
        for (int it = 0; it < 8; it++) begin
            bit bad;
            bad = ($urandom_range(3, 0) == 0);
            do_reset();
            build_frame(int'($urandom_range(6, 1)), bad);
            drive_frame(3);
            check_result("rand", !bad, bad);
            if (bad) begin
                wr_q = {};
                frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'h01;
                drive_frame(2);
                check_result("rand_retry", 1'b1, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
